// File: rtl/atx_pll_recal_pkg.sv
// Shared definitions for the ATX PLL recalibration controller:
// FSM encoding, failure codes and arbitration register values.
package atx_pll_recal_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ_BUS,
    ST_POLL_OWN,
    ST_RD_CAL,
    ST_WR_CAL,
    ST_REL_BUS,
    ST_WAIT_CAL_HI,
    ST_WAIT_CAL_LO,
    ST_WAIT_LOCK,
    ST_FINISH
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OWN  = 2'd1;
  localparam logic [1:0] ERR_CAL  = 2'd2;
  localparam logic [1:0] ERR_LOCK = 2'd3;

  localparam logic [31:0] ARB_RELEASE = 32'h1;
  localparam logic [31:0] ARB_REQUEST = 32'h2;

  // Bit of the status register that stays set while another
  // agent still owns the reconfiguration bus.
  localparam int unsigned STAT_OWN_BIT = 2;

endpackage

// File: rtl/atx_pll_recal_ctrl_sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
// Clears to 0 on reset.
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/atx_pll_recal_ctrl.sv
// ATX PLL recalibration sequencer: takes bus ownership, sets the
// calibration enable, releases the bus and waits for cal and lock.
module atx_pll_recal_ctrl
  import atx_pll_recal_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [10:0] ARB_ADDR       = 11'h000,
  parameter logic [10:0] STAT_ADDR      = 11'h280,
  parameter logic [10:0] CAL_ADDR       = 11'h100,
  parameter logic [31:0] CAL_MASK       = 32'h0000_0001
) (
  input  logic        reconfig_clk,
  input  logic        reconfig_reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic        avmm_write,
  output logic        avmm_read,
  output logic [10:0] avmm_address,
  output logic [31:0] avmm_writedata,
  input  logic [31:0] avmm_readdata,
  input  logic        avmm_waitrequest,
  input  logic        pll_cal_busy,
  input  logic        pll_locked
);

  localparam logic [31:0] TC = 32'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [31:0] cnt_q;
  logic [31:0] cal_q;
  logic [1:0]  fail_q;
  logic [1:0]  err_q;
  logic        wr_q;
  logic        rd_q;
  logic [10:0] addr_q;
  logic [31:0] wdata_q;

  logic cal_busy_s;
  logic locked_s;
  logic tc;
  logic counting;
  logic acc;

  sync2 u_sync_cal (
    .clk_i  (reconfig_clk),
    .rst_ni (reconfig_reset_n),
    .d_i    (pll_cal_busy),
    .q_o    (cal_busy_s)
  );

  sync2 u_sync_lock (
    .clk_i  (reconfig_clk),
    .rst_ni (reconfig_reset_n),
    .d_i    (pll_locked),
    .q_o    (locked_s)
  );

  assign tc  = cnt_q >= TC;
  assign acc = !avmm_waitrequest;

  assign counting = (state_q == ST_POLL_OWN)
                 || (state_q == ST_WAIT_CAL_HI)
                 || (state_q == ST_WAIT_CAL_LO)
                 || (state_q == ST_WAIT_LOCK);

  always_ff @(posedge reconfig_clk or negedge reconfig_reset_n) begin
    if (!reconfig_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cal_q   <= '0;
      fail_q  <= ERR_NONE;
      err_q   <= ERR_NONE;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      cnt_q <= counting ? cnt_q + 32'd1 : '0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_REQ_BUS;
            cnt_q   <= '0;
            fail_q  <= ERR_NONE;
            err_q   <= ERR_NONE;
          end
        end
        ST_REQ_BUS: begin
          if (!wr_q) begin
            wr_q    <= 1'b1;
            addr_q  <= ARB_ADDR;
            wdata_q <= ARB_REQUEST;
          end else if (acc) begin
            wr_q    <= 1'b0;
            state_q <= ST_POLL_OWN;
            cnt_q   <= '0;
          end
        end
        ST_POLL_OWN: begin
          // Give up only between reads; an issued read must finish.
          if (!rd_q) begin
            if (tc) begin
              state_q <= ST_REL_BUS;
              fail_q  <= ERR_OWN;
              cnt_q   <= '0;
            end else begin
              rd_q   <= 1'b1;
              addr_q <= STAT_ADDR;
            end
          end else if (acc) begin
            rd_q <= 1'b0;
            if (!avmm_readdata[STAT_OWN_BIT]) begin
              state_q <= ST_RD_CAL;
              cnt_q   <= '0;
            end else if (tc) begin
              state_q <= ST_REL_BUS;
              fail_q  <= ERR_OWN;
              cnt_q   <= '0;
            end
          end
        end
        ST_RD_CAL: begin
          if (!rd_q) begin
            rd_q   <= 1'b1;
            addr_q <= CAL_ADDR;
          end else if (acc) begin
            rd_q    <= 1'b0;
            cal_q   <= avmm_readdata;
            state_q <= ST_WR_CAL;
          end
        end
        ST_WR_CAL: begin
          if (!wr_q) begin
            wr_q    <= 1'b1;
            addr_q  <= CAL_ADDR;
            wdata_q <= cal_q | CAL_MASK;
          end else if (acc) begin
            wr_q    <= 1'b0;
            state_q <= ST_REL_BUS;
          end
        end
        ST_REL_BUS: begin
          if (!wr_q) begin
            wr_q    <= 1'b1;
            addr_q  <= ARB_ADDR;
            wdata_q <= ARB_RELEASE;
          end else if (acc) begin
            wr_q    <= 1'b0;
            state_q <= (fail_q != ERR_NONE) ? ST_FINISH : ST_WAIT_CAL_HI;
            cnt_q   <= '0;
          end
        end
        ST_WAIT_CAL_HI: begin
          if (cal_busy_s) begin
            state_q <= ST_WAIT_CAL_LO;
            cnt_q   <= '0;
          end else if (tc) begin
            state_q <= ST_FINISH;
            fail_q  <= ERR_CAL;
          end
        end
        ST_WAIT_CAL_LO: begin
          if (!cal_busy_s) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
          end else if (tc) begin
            state_q <= ST_FINISH;
            fail_q  <= ERR_CAL;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_q <= ST_FINISH;
          end else if (tc) begin
            state_q <= ST_FINISH;
            fail_q  <= ERR_LOCK;
          end
        end
        ST_FINISH: begin
          err_q   <= fail_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy  = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign done  = (state_q == ST_FINISH) && (fail_q == ERR_NONE);
  assign error = (state_q == ST_FINISH) && (fail_q != ERR_NONE);

  // The code shows with the error pulse and is then held in err_q.
  assign err_code = (state_q == ST_FINISH) ? fail_q : err_q;

  assign avmm_write     = wr_q;
  assign avmm_read      = rd_q;
  assign avmm_address   = addr_q;
  assign avmm_writedata = wdata_q;

endmodule

// File: tb/tb_atx_pll_recal_ctrl.sv
// Scoreboard bench for atx_pll_recal_ctrl: AVMM slave, PLL model,
// expected bus writes and outcomes queued per recalibration run.
module tb_atx_pll_recal_ctrl;

  localparam int TO = 64;

  typedef struct {
    bit          is_end;
    logic [10:0] a;
    logic [31:0] d;
    logic [1:0]  code;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic        wr;
  logic        rd;
  logic [10:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        waitreq;
  logic        pll_cal_busy = 1'b0;
  logic        pll_locked = 1'b0;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int rel_seen = 0;
  int ends = 0;
  logic [1:0] last_code = 2'd0;

  int          stall_n = 0;
  int          stall_cnt = 0;
  int          own_busy_n = 0;
  int          polls = 0;
  int          poll_base = 0;
  logic [31:0] cal_val = 32'h0;
  logic [31:0] stat_noise = 32'h0;
  bit          hold_cal_wr = 1'b0;

  always #5 clk = ~clk;

  atx_pll_recal_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .reconfig_clk     (clk),
    .reconfig_reset_n (rst_n),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .err_code         (err_code),
    .avmm_write       (wr),
    .avmm_read        (rd),
    .avmm_address     (addr),
    .avmm_writedata   (wdata),
    .avmm_readdata    (rdata),
    .avmm_waitrequest (waitreq),
    .pll_cal_busy     (pll_cal_busy),
    .pll_locked       (pll_locked)
  );

  // AVMM slave: stall_n wait cycles per access, optional endless stall
  // on the calibration write, status bit2 set for own_busy_n polls.
  assign waitreq = (wr || rd)
    && ((hold_cal_wr && wr && addr == 11'h100) || stall_cnt < stall_n);

  assign rdata = (addr == 11'h280)
    ? ((((polls - poll_base) < own_busy_n) ? 32'h4 : 32'h0) | stat_noise)
    : (addr == 11'h100) ? cal_val : 32'h0;

  initial forever begin
    @(posedge clk);
    stall_cnt <= ((wr || rd) && waitreq) ? stall_cnt + 1 : 0;
    if (rd && !waitreq && addr == 11'h280) polls <= polls + 1;
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic void push_w(input logic [10:0] a, input logic [31:0] d);
    exp_t e;
    e.is_end = 1'b0;
    e.a = a;
    e.d = d;
    e.code = 2'd0;
    q.push_back(e);
  endfunction

  function automatic void push_end(input logic [1:0] c);
    exp_t e;
    e.is_end = 1'b1;
    e.a = 11'h0;
    e.d = 32'h0;
    e.code = c;
    q.push_back(e);
  endfunction

  // Monitor: pops the scoreboard on every accepted write and on every
  // done/error pulse; also checks the bus protocol rules each cycle.
  initial begin
    logic pw, pr, pwt;
    logic [10:0] pa;
    logic [31:0] pd;
    bit pv;
    exp_t e;
    pv = 1'b0;
    pw = 1'b0; pr = 1'b0; pwt = 1'b0; pa = '0; pd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv && (pw || pr) && pwt)
          chk("stall_hold", 64'({wr, rd, addr, wdata}),
              64'({pw, pr, pa, pd}));
        if (pv && (pw || pr) && !pwt)
          chk("drop_after_accept", 64'({wr, rd}), 64'(0));
        if (wr || rd) chk("rd_wr_excl", 64'(wr && rd), 64'(0));
        if (wr && !waitreq) begin
          if (q.size() == 0) begin
            chk("unexpected_write", 64'({addr, wdata}), 64'(0));
          end else begin
            e = q.pop_front();
            chk("write_kind", 64'(e.is_end), 64'(0));
            chk("write_addr", 64'(addr), 64'(e.a));
            chk("write_data", 64'(wdata), 64'(e.d));
          end
          if (addr == 11'h000 && wdata == 32'h1) rel_seen++;
        end
        if (done || error) begin
          chk("busy_at_end", 64'(busy), 64'(0));
          if (q.size() == 0) begin
            chk("unexpected_end", 64'({done, error, err_code}), 64'(0));
          end else begin
            e = q.pop_front();
            chk("end_kind", 64'(e.is_end), 64'(1));
            chk("end_flags", 64'({done, error, err_code}),
                64'({e.code == 2'd0, e.code != 2'd0, e.code}));
          end
          ends++;
        end
        pv = 1'b1;
        pw = wr; pr = rd; pwt = waitreq; pa = addr; pd = wdata;
      end
    end
  end

  task automatic pulse_start();
    chk("errcode_held", 64'(err_code), 64'(last_code));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("errcode_cleared", 64'(err_code), 64'(0));
  endtask

  // mode: 0 normal, 1 cal never rises, 2 lock never rises,
  // 3 lock on the terminal-count cycle, 4 lock one cycle too late.
  task automatic run(input int st, input int own_n, input logic [31:0] cal,
                     input int mode, input int d_hi, input int len,
                     input int d_lock, input bit poke);
    logic [1:0] code;
    int e0, r0;
    stall_n = st;
    own_busy_n = own_n;
    poll_base = polls;
    cal_val = cal;
    pll_cal_busy = 1'b0;
    pll_locked = 1'b0;
    if (own_n > 100) code = 2'd1;
    else if (mode == 1) code = 2'd2;
    else if (mode == 2 || mode == 4) code = 2'd3;
    else code = 2'd0;
    push_w(11'h000, 32'h2);
    if (code != 2'd1) push_w(11'h100, cal | 32'h1);
    push_w(11'h000, 32'h1);
    push_end(code);
    e0 = ends;
    r0 = rel_seen;
    pulse_start();
    if (code != 2'd1) begin
      for (int i = 0; i < 3000 && rel_seen == r0; i++) @(negedge clk);
      chk("rel_write_seen", 64'(rel_seen != r0), 64'(1));
      if (mode != 1) begin
        repeat (d_hi) @(negedge clk);
        pll_cal_busy = 1'b1;
        repeat (len) @(negedge clk);
        pll_cal_busy = 1'b0;
        if (mode == 3) begin
          repeat (64) @(negedge clk);
          pll_locked = 1'b1;
        end else if (mode == 4) begin
          repeat (65) @(negedge clk);
          pll_locked = 1'b1;
        end else if (mode == 0) begin
          if (poke) begin
            repeat (4) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (d_lock - 5) @(negedge clk);
          end else begin
            repeat (d_lock) @(negedge clk);
          end
          pll_locked = 1'b1;
        end
      end
    end
    for (int i = 0; i < 4000 && ends == e0; i++) @(negedge clk);
    chk("end_seen", 64'(ends != e0), 64'(1));
    repeat (3) @(negedge clk);
    chk("idle_after_end", 64'(busy), 64'(0));
    chk("queue_drained", 64'(q.size()), 64'(0));
    last_code = code;
  endtask

  task automatic reset_mid();
    bit seen;
    stall_n = 0;
    own_busy_n = 0;
    poll_base = polls;
    cal_val = 32'h10;
    stat_noise = 32'h0;
    hold_cal_wr = 1'b1;
    pll_cal_busy = 1'b0;
    pll_locked = 1'b0;
    push_w(11'h000, 32'h2);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      seen = wr && (addr == 11'h100);
    end
    chk("cal_write_reached", 64'(seen), 64'(1));
    repeat (3) @(negedge clk);
    chk("cal_write_stalled", 64'({wr, waitreq}), 64'(2'b11));
    rst_n = 1'b0;
    #1;
    chk("rst_write_low", 64'({wr, rd}), 64'(0));
    chk("rst_busy_low", 64'(busy), 64'(0));
    chk("rst_bus_zero", 64'({addr, wdata}), 64'(0));
    chk("rst_flags_zero", 64'({done, error, err_code}), 64'(0));
    q.delete();
    hold_cal_wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_code = 2'd0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, own;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_pulses", 64'({done, error}), 64'(0));
    chk("reset_errcode", 64'(err_code), 64'(0));
    chk("reset_bus", 64'({wr, rd, addr, wdata}), 64'(0));
    rst_n = 1'b1;

    run(0, 0, 32'h10, 0, 5, 50, 10, 1'b0);
    run(7, 0, 32'h10, 0, 5, 50, 10, 1'b0);
    run(3, 1000000, 32'h10, 0, 5, 50, 10, 1'b0);
    run(0, 0, 32'hA5A5_0000, 2, 5, 30, 10, 1'b0);
    repeat (5) @(negedge clk);
    chk("errcode_holds_3", 64'(err_code), 64'(3));
    run(0, 2, 32'h10, 0, 5, 20, 12, 1'b1);
    run(0, 0, 32'h10, 3, 5, 20, 0, 1'b0);
    run(0, 0, 32'h10, 4, 5, 20, 0, 1'b0);
    run(1, 0, 32'hFFFF_FFFE, 1, 5, 20, 10, 1'b0);
    reset_mid();
    run(0, 0, 32'h10, 0, 5, 50, 10, 1'b0);

    for (int k = 0; k < 10; k++) begin
      m = $urandom_range(0, 9);
      own = (m == 0) ? 1000000 : $urandom_range(0, 3);
      stat_noise = $urandom & 32'hFFFF_FFFB;
      run($urandom_range(0, 7), own, $urandom,
          (m == 1) ? 1 : (m == 2) ? 2 : 0,
          $urandom_range(1, 20), $urandom_range(5, 40),
          $urandom_range(8, 30), m[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
